// File: rtl/alu_op_sequencer.sv
// Command-side sequencer for the 16-bit ALU: decodes register-to-register instructions, reads an
// internal register file, issues one ALU operation and returns the result over a handshake.
module alu_op_sequencer #(
    parameter int unsigned NREGS = 8,
    parameter int unsigned DW    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [13:0]              instr,
    input  logic                     ld_en,
    input  logic [$clog2(NREGS)-1:0] ld_addr,
    input  logic [DW-1:0]            ld_data,
    output logic [DW-1:0]            alu_a,
    output logic [DW-1:0]            alu_b,
    output logic [4:0]               alu_code,
    input  logic [DW-1:0]            alu_c,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [DW-1:0]            res_data,
    output logic [$clog2(NREGS)-1:0] res_rd,
    output logic                     res_err,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [DW-1:0]            dbg_data
);

    localparam int unsigned AW = $clog2(NREGS);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StResp
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   regs_q [NREGS];
    logic [DW-1:0]   regs_d [NREGS];
    logic [4:0]      code_q, code_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [DW-1:0]   alu_a_q, alu_a_d;
    logic [DW-1:0]   alu_b_q, alu_b_d;
    logic            instr_ready_q, instr_ready_d;
    logic            res_valid_q, res_valid_d;
    logic [DW-1:0]   res_data_q, res_data_d;
    logic [AW-1:0]   res_rd_q, res_rd_d;
    logic            res_err_q, res_err_d;

    logic [4:0]      instr_code;
    logic [AW-1:0]   instr_rd;
    logic [AW-1:0]   instr_rs1;
    logic [AW-1:0]   instr_rs2;
    logic [DW-1:0]   op_a_fwd;
    logic [DW-1:0]   op_b_fwd;
    logic            code_legal;

    assign instr_code = instr[13:9];
    assign instr_rd   = instr[8:6];
    assign instr_rs1  = instr[5:3];
    assign instr_rs2  = instr[2:0];

    // Operands are captured on the accept edge; forward a coincident load so the ISSUE cycle
    // sees exactly what the register file holds after that edge.
    assign op_a_fwd = (ld_en && (ld_addr == instr_rs1)) ? ld_data : regs_q[instr_rs1];
    assign op_b_fwd = (ld_en && (ld_addr == instr_rs2)) ? ld_data : regs_q[instr_rs2];

    assign code_legal = code_q inside {[5'd0 : 5'd5], 5'd8, 5'd9, 5'd10, 5'd12,
                                       [5'd16 : 5'd19], [5'd24 : 5'd29]};

    always_comb begin
        state_d       = state_q;
        regs_d        = regs_q;
        code_d        = code_q;
        rd_d          = rd_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        instr_ready_d = instr_ready_q;
        res_valid_d   = res_valid_q;
        res_data_d    = res_data_q;
        res_rd_d      = res_rd_q;
        res_err_d     = res_err_q;

        if (ld_en) begin
            regs_d[ld_addr] = ld_data;
        end

        unique case (state_q)
            StIdle: begin
                if (instr_valid && instr_ready_q) begin
                    code_d        = instr_code;
                    rd_d          = instr_rd;
                    alu_a_d       = op_a_fwd;
                    alu_b_d       = op_b_fwd;
                    instr_ready_d = 1'b0;
                    state_d       = StIssue;
                end
            end
            StIssue: begin
                res_rd_d    = rd_q;
                res_valid_d = 1'b1;
                state_d     = StResp;
                if (code_legal) begin
                    res_data_d   = alu_c;
                    res_err_d    = 1'b0;
                    // Assigned after the load so the ALU writeback wins on an address clash.
                    regs_d[rd_q] = alu_c;
                end else begin
                    res_data_d = '0;
                    res_err_d  = 1'b1;
                end
            end
            StResp: begin
                if (res_ready) begin
                    res_valid_d   = 1'b0;
                    instr_ready_d = 1'b1;
                    state_d       = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            regs_q        <= '{default: '0};
            code_q        <= '0;
            rd_q          <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            instr_ready_q <= 1'b1;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_rd_q      <= '0;
            res_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            regs_q        <= regs_d;
            code_q        <= code_d;
            rd_q          <= rd_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            instr_ready_q <= instr_ready_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_rd_q      <= res_rd_d;
            res_err_q     <= res_err_d;
        end
    end

    assign instr_ready = instr_ready_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_code    = code_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_rd      = res_rd_q;
    assign res_err     = res_err_q;
    assign dbg_data    = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: a stand-in ALU, a transaction-level reference model that
// queues expected results, and a negedge monitor that compares everything the DUT presents.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [13:0] instr = '0;
    logic        ld_en = 1'b0;
    logic [2:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic [15:0] alu_a, alu_b, alu_c;
    logic [4:0]  alu_code;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [15:0] res_data;
    logic [2:0]  res_rd;
    logic        res_err;
    logic [2:0]  dbg_addr = '0;
    logic [15:0] dbg_data;

    alu_op_sequencer #(.NREGS(8), .DW(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_code    (alu_code),
        .alu_c       (alu_c),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_rd      (res_rd),
        .res_err     (res_err),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    // Stand-in for the external ALU; illegal codes still produce a non-zero value.
    function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [4:0] c);
        case (c)
            5'd0:    return a + b;
            5'd1:    return a + b + 16'd1;
            5'd2:    return a - b;
            5'd3:    return b - a;
            5'd4:    return a & b;
            5'd5:    return a | b;
            5'd8:    return a ^ b;
            5'd9:    return ~a;
            5'd10:   return a << b[3:0];
            5'd12:   return a >> b[3:0];
            default: return a ^ b ^ {c, 11'h2a5};
        endcase
    endfunction

    function automatic bit legal(input logic [4:0] c);
        return c inside {[0:5], 8, 9, 10, 12, [16:19], [24:29]};
    endfunction

    assign alu_c = alu_fn(alu_a, alu_b, alu_code);

    typedef struct {
        logic [15:0] data;
        logic [2:0]  rd;
        logic        err;
    } res_t;

    // Reference model state
    logic [15:0] mregs [8];
    bit          m_ready = 1'b1;
    bit          m_issue = 1'b0;
    bit          m_resp  = 1'b0;
    logic [4:0]  m_code;
    logic [2:0]  m_rd, m_rs1, m_rs2;
    res_t        exp_q [$];

    // Stimulus control
    bit          rand_ld = 1'b0;
    int          rr_mode = 0;
    bit          dir_ld_en = 1'b0;
    logic [2:0]  dir_ld_addr = '0;
    logic [15:0] dir_ld_data = '0;
    bit          chk_en = 1'b0;
    logic [2:0]  chk_addr = '0;
    logic [15:0] chk_val = '0;
    bit          done = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    initial begin
        foreach (mregs[i]) mregs[i] = '0;
        m_code = '0; m_rd = '0; m_rs1 = '0; m_rs2 = '0;
    end

    // Reference model: one transaction = accept, one issue cycle, then a held result.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            foreach (mregs[i]) mregs[i] = '0;
            m_ready = 1'b1; m_issue = 1'b0; m_resp = 1'b0;
            exp_q.delete();
        end else begin
            bit          hs, acc, ok;
            logic [15:0] r;
            hs  = m_resp && res_ready;
            acc = m_ready && instr_valid;
            ok  = legal(m_code);
            r   = ok ? alu_fn(mregs[m_rs1], mregs[m_rs2], m_code) : 16'h0000;
            if (m_issue) exp_q.push_back('{data: r, rd: m_rd, err: !ok});
            if (ld_en) mregs[ld_addr] = ld_data;
            if (m_issue && ok) mregs[m_rd] = r;
            if (m_issue) m_resp = 1'b1;
            else if (hs) m_resp = 1'b0;
            if (acc) m_ready = 1'b0;
            else if (hs) m_ready = 1'b1;
            if (acc) begin
                m_code = instr[13:9]; m_rd = instr[8:6]; m_rs1 = instr[5:3]; m_rs2 = instr[2:0];
            end
            m_issue = acc;
        end
    end

    // Load / debug / result-ready driver
    initial forever begin
        @(posedge clk);
        #2;
        if (rand_ld) begin
            ld_en   = ($urandom % 3) == 0;
            ld_addr = 3'($urandom);
            ld_data = 16'($urandom);
        end else begin
            ld_en   = dir_ld_en;
            ld_addr = dir_ld_addr;
            ld_data = dir_ld_data;
        end
        dbg_addr  = chk_en ? chk_addr : 3'($urandom);
        res_ready = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? 1'($urandom) : 1'b0;
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // Monitor
    initial forever begin
        @(negedge clk);
        chk("instr_ready", 16'(instr_ready), 16'(m_ready));
        chk("res_valid", 16'(res_valid), 16'(m_resp));
        chk("dbg_data", dbg_data, mregs[dbg_addr]);
        if (chk_en) chk("reg_check", dbg_data, chk_val);
        if (!rst_n) begin
            chk("rst_alu_a", alu_a, 16'h0);
            chk("rst_alu_b", alu_b, 16'h0);
            chk("rst_alu_code", 16'(alu_code), 16'h0);
            chk("rst_res_data", res_data, 16'h0);
            chk("rst_res_rd", 16'(res_rd), 16'h0);
            chk("rst_res_err", 16'(res_err), 16'h0);
        end else if (m_issue) begin
            chk("alu_a", alu_a, mregs[m_rs1]);
            chk("alu_b", alu_b, mregs[m_rs2]);
            chk("alu_code", 16'(alu_code), 16'(m_code));
        end
        if (rst_n && res_valid && m_resp) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL result_unexpected at %0t: got %h, expected none", $time, res_data);
            end else begin
                chk("res_data", res_data, exp_q[0].data);
                chk("res_rd", 16'(res_rd), 16'(exp_q[0].rd));
                chk("res_err", 16'(res_err), 16'(exp_q[0].err));
                if (res_ready) void'(exp_q.pop_front());
            end
        end
        if (done) begin
            chk("leftover_results", 16'(exp_q.size()), 16'h0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $finish;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end

    // All main-thread tasks run with time positioned just after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        dir_ld_en = 1'b1; dir_ld_addr = a; dir_ld_data = d;
        step();
        dir_ld_en = 1'b0;
    endtask

    task automatic check_reg(input logic [2:0] a, input logic [15:0] v);
        chk_en = 1'b1; chk_addr = a; chk_val = v;
        step();
        chk_en = 1'b0;
    endtask

    task automatic issue(input logic [4:0] c, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input bit rst_in_issue, input bit do_ld,
                         input logic [2:0] la, input logic [15:0] ldv);
        int t = 0;
        instr = {c, rd, rs1, rs2};
        instr_valid = 1'b1;
        while (!m_ready) begin
            step();
            t++;
            if (t > 200) begin
                $display("FAIL issue_timeout: got no accept, expected accept within 200 cycles");
                $fatal(1);
            end
        end
        step();
        instr_valid = 1'b0;
        instr = 14'($urandom);
        if (do_ld) begin
            dir_ld_en = 1'b1; dir_ld_addr = la; dir_ld_data = ldv;
        end
        if (rst_in_issue) rst_n = 1'b0;
        step();
        dir_ld_en = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(m_ready && !m_resp)) begin
            step();
            t++;
            if (t > 200) begin
                $display("FAIL idle_timeout: got busy, expected idle within 200 cycles");
                $fatal(1);
            end
        end
    endtask

    initial begin
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Basic add
        load(3'd1, 16'h0005);
        load(3'd2, 16'h0003);
        issue(5'b00000, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 16'h0);
        wait_idle();
        check_reg(3'd3, 16'h0008);

        // Subtract with destination = source
        load(3'd1, 16'h0003);
        load(3'd2, 16'h0005);
        issue(5'b00010, 3'd1, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 16'h0);
        wait_idle();
        check_reg(3'd1, 16'hFFFE);

        // Illegal code: no writeback
        load(3'd4, 16'h1234);
        issue(5'b00110, 3'd4, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 16'h0);
        wait_idle();
        check_reg(3'd4, 16'h1234);

        // Backpressure
        rr_mode = 2;
        issue(5'b00000, 3'd6, 3'd4, 3'd4, 1'b0, 1'b0, 3'd0, 16'h0);
        repeat (6) step();
        rr_mode = 0;
        wait_idle();
        check_reg(3'd6, 16'h2468);

        // Write collisions in the ISSUE cycle
        load(3'd1, 16'h0005);
        load(3'd2, 16'h0003);
        issue(5'b00000, 3'd3, 3'd1, 3'd2, 1'b0, 1'b1, 3'd3, 16'hAAAA);
        wait_idle();
        check_reg(3'd3, 16'h0008);
        issue(5'b00000, 3'd3, 3'd1, 3'd2, 1'b0, 1'b1, 3'd5, 16'hBEEF);
        wait_idle();
        check_reg(3'd5, 16'hBEEF);
        check_reg(3'd3, 16'h0008);

        // Reset during ISSUE
        issue(5'b00000, 3'd7, 3'd1, 3'd2, 1'b1, 1'b0, 3'd0, 16'h0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 8; i++) check_reg(3'(i), 16'h0000);

        // Randomized traffic
        rand_ld = 1'b1;
        rr_mode = 1;
        for (int n = 0; n < 80; n++) begin
            issue(5'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                  1'b0, 1'b0, 3'd0, 16'h0);
            repeat ($urandom_range(0, 2)) step();
        end
        rand_ld = 1'b0;
        rr_mode = 0;
        wait_idle();
        step();
        done = 1'b1;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command-side driver for the team's 16-bit combinational ALU (operands A/B, 5-bit alu_code, result C).
- Accepts register-to-register instructions over a valid/ready handshake and reads operands from an internal 8x16 register file.
- Drives the ALU operand/code lines, captures the ALU result, writes it back to the destination register and presents it on a result handshake.
- Sits between an instruction source and the ALU instance; the ALU itself is instantiated outside this block.

Parameters:
- NREGS, 8, number of register-file entries (fixed power of two; address width 3).
- DW, 16, datapath width; must match the ALU.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- instr_valid  input  1  instruction offered.
- instr_ready  output  1  sequencer can accept an instruction.
- instr  input  14  [13:9] alu_code, [8:6] rd, [5:3] rs1, [2:0] rs2.
- ld_en  input  1  direct register load strobe.
- ld_addr  input  3  load address.
- ld_data  input  16  load data.
- alu_a  output  16  to ALU A.
- alu_b  output  16  to ALU B.
- alu_code  output  5  to ALU code.
- alu_c  input  16  from ALU C.
- res_valid  output  1  result available.
- res_ready  input  1  result consumer ready.
- res_data  output  16  captured result.
- res_rd  output  3  destination register of the result.
- res_err  output  1  instruction carried an unsupported alu_code.
- dbg_addr  input  3  debug read address.
- dbg_data  output  16  combinational read of regfile[dbg_addr].

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - State is IDLE; all registers = 0x0000.
  - res_valid = 0, res_data = 0, res_rd = 0, res_err = 0.
  - alu_a = 0, alu_b = 0, alu_code = 0.
  - instr_ready = 1 after reset.
- State machine: IDLE -> ISSUE -> RESP -> IDLE.
- IDLE:
  - instr_ready = 1.
  - On instr_valid & instr_ready, latch the instruction fields; next state is ISSUE.
- ISSUE (exactly 1 cycle):
  - instr_ready = 0.
  - alu_a = reg[rs1], alu_b = reg[rs2], alu_code = latched code, all driven from registered state.
  - At the end of the cycle, capture alu_c into res_data and latch rd into res_rd.
  - If the code is legal, write alu_c to reg[rd] and set res_err = 0.
  - If the code is illegal, do not write back, set res_data = 0x0000 and res_err = 1.
  - Next state is RESP.
- Legal codes:
  - 00000 to 00101.
  - 01000, 01001, 01010, 01100.
  - 10000 to 10011.
  - 11000 to 11101.
  - Everything else is illegal.
- RESP:
  - res_valid = 1; res_data, res_rd and res_err are held stable.
  - instr_ready = 0.
  - On res_valid & res_ready, clear res_valid and go to IDLE.
  - No combinational path from res_ready to instr_ready; the earliest next accept is the cycle after the result handshake.
- Latency: accept at cycle N; res_valid is high from cycle N+2; a back-to-back issue rate is at most one instruction per 3 cycles.
- alu_a, alu_b and alu_code hold their last values outside ISSUE.
- rd = rs1 or rs2 is allowed: operands are sampled before the writeback edge.
- ld_en:
  - Honoured in any state; writes ld_data to reg[ld_addr] at the clock edge.
  - If it coincides with the ISSUE writeback to the same address, the ALU writeback wins.
  - A load to an operand register during ISSUE does not affect the current operands; both paths see the pre-edge value.
- dbg_data reflects register contents after the most recent edge.
- Reset asserted mid-operation: immediate return to IDLE, all outputs to reset values, register file cleared; an instruction in flight is dropped without writeback.
- instr_valid while not ready: ignored; the source must hold it.

Test Plan:
- Basic add: load r1=0x0005, r2=0x0003, issue code 00000 rd=3 rs1=1 rs2=2 -> res_valid 2 cycles after accept, res_data=0x0008, res_rd=3, res_err=0; dbg r3 reads 0x0008.
- Subtract with operand reuse: r1=0x0003, r2=0x0005, code 00010 rd=1 rs1=1 rs2=2 -> res_data=0xFFFE; r1 becomes 0xFFFE after ISSUE.
- Illegal code: code 00110, rd=4, r4=0x1234 -> res_err=1, res_data=0x0000, r4 stays 0x1234.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid -> res_data, res_rd and res_err stable; instr_ready=0 throughout; instr_ready=1 the cycle after the handshake.
- Write collision: ld_en to r3 with 0xAAAA in the ISSUE cycle of add rd=3 (result 0x0008) -> r3=0x0008. Separately, a load to r5 with 0xBEEF in the same cycle -> r5=0xBEEF.
- Reset mid-op: deassert rst_n during ISSUE -> res_valid=0 and instr_ready=1 after release; all registers read 0x0000; no stale result appears.
